// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache controller.
//   state_t    : controller FSM states
//   meta_t     : per-way line metadata view (tag, valid, dirty); the tag field
//                is sized for the widest supported tag and holds the real tag
//                zero-extended
//   *_width()  : offset / index / tag / way-select widths derived from the
//                module parameters
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_REFILL    = 3'd3,
    ST_RESPOND   = 3'd4
  } state_t;

  localparam int MAX_TAG_W = 64;

  typedef struct packed {
    logic [MAX_TAG_W-1:0] tag;
    logic                 valid;
    logic                 dirty;
  } meta_t;

  function automatic int off_width(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int idx_width(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_width(input int addr_w, input int sets, input int line_bytes);
    return addr_w - $clog2(sets) - $clog2(line_bytes);
  endfunction

  // A direct-mapped cache still needs a one-bit way select to keep vectors legal.
  function automatic int sel_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/lru_tracker.sv
// True-LRU age storage for every set plus victim selection.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (ages return to age[w]=w)
//   set_idx    : set being looked up / updated
//   valid_vec  : valid bit of each way in that set
//   upd_en     : apply an access to way upd_way of set set_idx
//   upd_way    : accessed way
//   victim     : lowest-index invalid way, otherwise the oldest way
module lru_tracker
  import cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 16,
  localparam int IDX_W = idx_width(SETS),
  localparam int WAY_W = sel_width(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [WAYS-1:0]  valid_vec,
  input  logic             upd_en,
  input  logic [WAY_W-1:0] upd_way,
  output logic [WAY_W-1:0] victim
);

  localparam int AGE_W = WAY_W;

  logic [AGE_W-1:0] age [SETS][WAYS];
  logic [AGE_W-1:0] old_age;
  logic             found;
  logic [AGE_W-1:0] max_age;

  assign old_age = age[set_idx][upd_way];

  // Ages within a set always form a permutation of 0..WAYS-1: the accessed
  // way becomes youngest and only the ways younger than it grow one older.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age[s][w] <= AGE_W'(w);
        end
      end
    end else if (upd_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == upd_way) begin
          age[set_idx][w] <= '0;
        end else if (age[set_idx][w] < old_age) begin
          age[set_idx][w] <= age[set_idx][w] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    victim  = '0;
    found   = 1'b0;
    max_age = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_vec[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age[set_idx][w] >= max_age) begin
          max_age = age[set_idx][w];
          victim  = WAY_W'(w);
        end
      end
    end
  end

endmodule

// File: rtl/sa_cache_ctrl.sv
// Set-associative, write-back, write-allocate cache controller with true LRU.
// Byte-wide CPU port with valid/ready request and a one-cycle response pulse;
// byte-wide memory port doing one beat per mem_ack for line writeback/refill.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   cpu_req_valid/ready, cpu_addr,
//   cpu_we, cpu_wdata             : CPU request (accepted only in IDLE)
//   cpu_rsp_valid, cpu_rdata      : completion pulse and read byte
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_ack, mem_rdata : memory beat interface
//   stat_access, stat_hit         : saturating lookup/hit counters
// Optional feature: define CACHE_STATS_EN to add the statistics counters and
// their ports; without it the controller behaves identically, minus counters.
module sa_cache_ctrl
  import cache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 16,
  parameter int LINE_BYTES = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_rsp_valid,
  output logic [7:0]        cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       stat_access,
  output logic [31:0]       stat_hit
`endif
);

  localparam int OFF_W = off_width(LINE_BYTES);
  localparam int IDX_W = idx_width(SETS);
  localparam int TAG_W = tag_width(ADDR_W, SETS, LINE_BYTES);
  localparam int WAY_W = sel_width(WAYS);

  state_t state, state_nxt;

  // Latched request
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [7:0]        req_wdata;
  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;

  // Line storage: tags/data carry no reset, valid/dirty do
  logic [TAG_W-1:0] tag_mem   [WAYS][SETS];
  logic [7:0]       line_data [WAYS][SETS][LINE_BYTES];
  logic             valid_q   [WAYS][SETS];
  logic             dirty_q   [WAYS][SETS];
  meta_t            set_meta  [WAYS];

  logic [WAY_W-1:0] way_sel;
  logic [OFF_W-1:0] beat;
  logic [7:0]       rdata_hold;

  logic [WAYS-1:0]  valid_vec;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;
  logic             victim_dirty;
  logic             last_beat;
  logic             rsp_read;

  assign req_off   = req_addr[OFF_W-1:0];
  assign req_idx   = req_addr[OFF_W +: IDX_W];
  assign req_tag   = req_addr[OFF_W+IDX_W +: TAG_W];
  assign last_beat = (beat == OFF_W'(LINE_BYTES-1));
  assign rsp_read  = (state == ST_RESPOND) && !req_we;

  // Metadata of the addressed set, compared across all ways in parallel
  always_comb begin
    valid_vec = '0;
    hit       = 1'b0;
    hit_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_meta[w]       = '0;
      set_meta[w].tag   = MAX_TAG_W'(tag_mem[w][req_idx]);
      set_meta[w].valid = valid_q[w][req_idx];
      set_meta[w].dirty = dirty_q[w][req_idx];
      valid_vec[w]      = set_meta[w].valid;
      if (set_meta[w].valid && (set_meta[w].tag == MAX_TAG_W'(req_tag))) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign victim_dirty = set_meta[victim].valid && set_meta[victim].dirty;

  // Every completed access (hit or filled miss) passes through RESPOND, so
  // ageing is applied once there.
  lru_tracker #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_idx   (req_idx),
    .valid_vec (valid_vec),
    .upd_en    (state == ST_RESPOND),
    .upd_way   (way_sel),
    .victim    (victim)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (cpu_req_valid) state_nxt = ST_LOOKUP;
      ST_LOOKUP: begin
        if (hit)               state_nxt = ST_RESPOND;
        else if (victim_dirty) state_nxt = ST_WRITEBACK;
        else                   state_nxt = ST_REFILL;
      end
      ST_WRITEBACK: if (mem_ack && last_beat) state_nxt = ST_REFILL;
      ST_REFILL:    if (mem_ack && last_beat) state_nxt = ST_RESPOND;
      ST_RESPOND:   state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; beat signals are pure functions of state and registers so
  // they hold steady until acked and vanish as soon as reset asserts.
  always_comb begin
    cpu_req_ready = (state == ST_IDLE);
    cpu_rsp_valid = (state == ST_RESPOND);
    cpu_rdata     = rdata_hold;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state)
      ST_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_mem[way_sel][req_idx], req_idx, beat};
        mem_wdata = line_data[way_sel][req_idx][beat];
      end
      ST_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, beat};
      end
      ST_RESPOND: begin
        if (!req_we) cpu_rdata = line_data[way_sel][req_idx][req_off];
      end
      default: ;
    endcase
  end

  // Request capture (IDLE only)
  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && cpu_req_valid) begin
      req_addr  <= cpu_addr;
      req_we    <= cpu_we;
      req_wdata <= cpu_wdata;
    end
  end

  // Way selection, beat counter and held read byte. The beat counter is
  // exactly OFF_W bits wide, so it wraps to 0 between writeback and refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      way_sel    <= '0;
      beat       <= '0;
      rdata_hold <= '0;
    end else begin
      case (state)
        ST_LOOKUP: begin
          way_sel <= hit ? hit_way : victim;
          beat    <= '0;
        end
        ST_WRITEBACK, ST_REFILL: if (mem_ack) beat <= beat + 1'b1;
        default: ;
      endcase
      if (rsp_read) rdata_hold <= line_data[way_sel][req_idx][req_off];
    end
  end

  // Line data and tag writes
  always_ff @(posedge clk) begin
    if ((state == ST_REFILL) && mem_ack) begin
      line_data[way_sel][req_idx][beat] <= mem_rdata;
      if (last_beat) tag_mem[way_sel][req_idx] <= req_tag;
    end
    if ((state == ST_RESPOND) && req_we) begin
      line_data[way_sel][req_idx][req_off] <= req_wdata;
    end
  end

  // Valid/dirty: cleared by reset, which discards any in-flight or dirty line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
    end else begin
      if ((state == ST_REFILL) && mem_ack && last_beat) begin
        valid_q[way_sel][req_idx] <= 1'b1;
        dirty_q[way_sel][req_idx] <= 1'b0;
      end
      if ((state == ST_RESPOND) && req_we) begin
        dirty_q[way_sel][req_idx] <= 1'b1;
      end
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_access <= '0;
      stat_hit    <= '0;
    end else if (state == ST_LOOKUP) begin
      if (stat_access != '1)        stat_access <= stat_access + 32'd1;
      if (hit && (stat_hit != '1))  stat_hit    <= stat_hit + 32'd1;
    end
  end
`endif

endmodule

// File: doc/sa_cache_ctrl.md
# sa_cache_ctrl

Parametrised set-associative, write-back, write-allocate cache controller with true-LRU replacement, sitting between a byte-wide CPU request port and a byte-wide main-memory port. It generalises the team's direct-mapped single-cycle cache to configurable ways, sets and line size. It adds valid/ready handshakes on both sides, a multi-cycle refill and writeback state machine, and optional hit statistics.

## Interface
- `WAYS`, 2, associativity (power of two, ≥1; 1 = direct-mapped)
- `SETS`, 16, sets (power of two, ≥2)
- `LINE_BYTES`, 8, bytes per line (power of two, ≥2)
- `ADDR_W`, 32, address width
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cpu_req_valid`  in  1  CPU request present
- `cpu_req_ready`  out  1  controller accepts request (IDLE only)
- `cpu_addr`  in  ADDR_W  byte address
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_wdata`  in  8  write byte
- `cpu_rsp_valid`  out  1  one-cycle completion pulse (reads and writes)
- `cpu_rdata`  out  8  read byte, valid with `cpu_rsp_valid`
- `mem_req`  out  1  memory beat request
- `mem_we`  out  1  beat is a write
- `mem_addr`  out  ADDR_W  beat byte address
- `mem_wdata`  out  8  writeback byte
- `mem_ack`  in  1  beat complete; `mem_rdata` valid same cycle
- `mem_rdata`  in  8  refill byte
- `stat_access`, `stat_hit`  out  32 each  counters (only with `CACHE_STATS_EN`)

## Operation
- Address split: offset = low log2(LINE_BYTES) bits, index = next log2(SETS) bits, tag = remainder.
- Per way/set: tag, valid, dirty, data line, LRU age (log2(WAYS) bits).
- FSM states: IDLE → LOOKUP → (hit) RESPOND → IDLE; (miss, clean victim) REFILL → RESPOND; (miss, dirty victim) WRITEBACK → REFILL → RESPOND.
- IDLE: `cpu_req_ready`=1; on valid&ready, latch addr/we/wdata.
- LOOKUP: compare all ways in parallel. Hit: update LRU, go to RESPOND. Miss: select the lowest-index invalid way, else the way with maximum age.
- WRITEBACK: LINE_BYTES beats, offsets 0..LINE_BYTES-1 ascending, `mem_we`=1, address = {victim tag, index, offset}.
- REFILL: LINE_BYTES beats ascending, `mem_we`=0, address = {req tag, index, offset}. Each acked byte is stored. At the end: tag written, valid=1, dirty=0.
- RESPOND: a read returns the byte. A write stores `cpu_wdata` and sets dirty=1. `cpu_rsp_valid`=1 for exactly one cycle. LRU updated on the accessed way.
- LRU update: accessed way's age → 0; ways with age less than its old age increment; others unchanged.
- `mem_ack` while `mem_req`=0 is ignored. CPU inputs outside IDLE are ignored.

## Timing
- Reset (async): FSM=IDLE, all valid/dirty=0, age[w]=w. All outputs 0 except `cpu_req_ready`=1. Counters=0.
- Hit latency: accept at edge T; `cpu_rsp_valid` high during cycle T+2.
- Each beat: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` held stable until the edge where `mem_ack`=1. The next beat is presented in the following cycle (`mem_req` may stay high).
- Miss latency = 2 + beat cycles (+ writeback beats) + 1 cycle for RESPOND.
- Reset mid-operation: `mem_req` drops immediately; the in-flight line and all dirty data are discarded.
- `cpu_rdata` holds its last value between responses.

## Configuration
- `CACHE_STATS_EN` defined: `stat_access` increments on every LOOKUP, `stat_hit` on every hit. Both are saturating 32-bit counters, cleared by reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `cache_pkg`: FSM state enum; localparams for offset/index/tag widths as functions of parameters; line metadata struct (tag, valid, dirty).
- Sub-module `lru_tracker`: per-set age storage, hit-way update, victim select (invalid-first, else max age).

## Test plan
Defaults apply: index = addr[6:3]; 0x000, 0x080 and 0x100 share set 0.
- Read 0x010 after reset: refill beats 0x010..0x017, `cpu_rdata`=mem[0x010]. Repeat the read: hit, rsp at T+2, no `mem_req`.
- Write 0xA5 @0x000, read 0x080, read 0x100: 8 writeback beats to 0x000..0x007 with the first `mem_wdata`=0xA5, then refill 0x100..0x107.
- Reads 0x000, 0x080, 0x000, 0x100: 0x080 line evicted with no writeback. A following read of 0x000 hits.
- `mem_ack` delayed 3 cycles per beat: beat signals stable, `cpu_req_ready`=0 throughout, 8 beats total.
- `rst_n` low during refill beat 4: `mem_req`=0 at once, `cpu_req_ready`=1 after release. A re-read of the same address misses.
- With `CACHE_STATS_EN`: read 0x010 ×3 → `stat_access`=3, `stat_hit`=2.
